pipemem_mmio: RTL and testbench

Parametrised memory-stage block for the pipelined CPU. It maps a data RAM and a register-based memory-mapped I/O space into one address space, selected by a single address bit. It goes beyond a plain mux-and-register I/O path by adding:
- configurable RAM depth and port counts,
- per-input change detection with clear-on-read status,
- per-output write strobes.

It sits between the EX/MEM and MEM/WB pipeline registers and drives `mmo` back to write-back.

---
 rtl/pipemem_mmio.sv | 122 ++++++++++++
 tb/tb_pipemem_mmio.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipemem_mmio.sv
// pipemem_mmio: pipeline memory stage mapping a data RAM and a register MMIO space into one address space.
// Define PIPEMEM_IN_SYNC_EN to pass every input port through a two-flop synchronizer before sampling.
module pipemem_mmio #(
  parameter int DEPTH_LOG2 = 5,
  parameter int NIN        = 2,
  parameter int NOUT       = 4,
  parameter int IO_SEL_BIT = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mwmem,
  input  logic                 mrmem,
  input  logic [31:0]          malu,
  input  logic [31:0]          mb,
  output logic [31:0]          mmo,
  input  logic [NIN*32-1:0]    in_ports,
  output logic [NOUT*32-1:0]   out_ports,
  output logic [NOUT-1:0]      out_wr,
  output logic [NIN-1:0]       in_new
);

  localparam int Words = 1 << DEPTH_LOG2;

  logic                      io;
  logic [DEPTH_LOG2-1:0]     ramIdx;
  logic [4:0]                k;
  logic                      statusRead;
  logic                      unusedAddrBits;

  assign io             = malu[IO_SEL_BIT];
  assign ramIdx         = malu[DEPTH_LOG2+1:2];
  assign k              = malu[6:2];
  assign statusRead     = mrmem && io && (k == 5'd31);
  assign unusedAddrBits = ^malu;

  logic [31:0] mem_q [Words];

  always_ff @(posedge clock) begin
    if (mwmem && !io) mem_q[ramIdx] <= mb;
  end

  logic [NOUT-1:0][31:0] outPorts_q;
  logic [NOUT-1:0]       outWr_d, outWr_q;

  always_comb begin
    outWr_d = '0;
    for (int i = 0; i < NOUT; i++) outWr_d[i] = mwmem && io && (k == 5'(i));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outPorts_q <= '0;
      outWr_q    <= '0;
    end else begin
      outWr_q <= outWr_d;
      for (int i = 0; i < NOUT; i++) begin
        if (outWr_d[i]) outPorts_q[i] <= mb;
      end
    end
  end

  assign out_ports = outPorts_q;
  assign out_wr    = outWr_q;

  logic [NIN-1:0][31:0] inStage, s_q;
  logic [NIN-1:0]       inNew_d, inNew_q;

`ifdef PIPEMEM_IN_SYNC_EN
  logic [NIN-1:0][31:0] sync1_q, sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_ports;
      sync2_q <= sync1_q;
    end
  end

  assign inStage = sync2_q;
`else
  assign inStage = in_ports;
`endif

  // A fresh change outranks a status read clearing the flag on the same edge.
  always_comb begin
    inNew_d = '0;
    for (int j = 0; j < NIN; j++) begin
      inNew_d[j] = (inStage[j] != s_q[j]) || (inNew_q[j] && !statusRead);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      inNew_q <= '0;
    end else begin
      s_q     <= inStage;
      inNew_q <= inNew_d;
    end
  end

  assign in_new = inNew_q;

  always_comb begin
    mmo = '0;
    if (!io) begin
      mmo = mem_q[ramIdx];
    end else if (k == 5'd31) begin
      mmo[NIN-1:0] = inNew_q;
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (k == 5'(i)) mmo = outPorts_q[i];
      end
      for (int j = 0; j < NIN; j++) begin
        if (k == 5'(16 + j)) mmo = s_q[j];
      end
    end
  end

endmodule

// File: tb/tb_pipemem_mmio.sv
// Self-checking bench for pipemem_mmio: directed steps followed by randomized traffic,
// all checked against a behavioural address-space model.
module tb_pipemem_mmio;

  localparam int DEPTH_LOG2 = 5;
  localparam int NIN        = 2;
  localparam int NOUT       = 4;
  localparam int IO_SEL_BIT = 7;
  localparam int WORDS      = 1 << DEPTH_LOG2;
`ifdef PIPEMEM_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                clock;
  logic                reset;
  logic                mwmem;
  logic                mrmem;
  logic [31:0]         malu;
  logic [31:0]         mb;
  logic [31:0]         mmo;
  logic [NIN*32-1:0]   in_ports;
  logic [NOUT*32-1:0]  out_ports;
  logic [NOUT-1:0]     out_wr;
  logic [NIN-1:0]      in_new;

  pipemem_mmio #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .NIN(NIN),
    .NOUT(NOUT),
    .IO_SEL_BIT(IO_SEL_BIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mwmem(mwmem),
    .mrmem(mrmem),
    .malu(malu),
    .mb(mb),
    .mmo(mmo),
    .in_ports(in_ports),
    .out_ports(out_ports),
    .out_wr(out_wr),
    .in_new(in_new)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [31:0]       ramM [WORDS];
  bit                ramV [WORDS];
  logic [31:0]       outM [NOUT];
  logic [NOUT-1:0]   wrM;
  logic [NIN-1:0]    newM;
  logic [31:0]       sM   [NIN];
  logic [NIN*32-1:0] pipeQ [$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs reach the sample register LAT edges after they are presented.
  task automatic modelReset();
    for (int i = 0; i < NOUT; i++) outM[i] = '0;
    for (int j = 0; j < NIN; j++) sM[j] = '0;
    wrM  = '0;
    newM = '0;
    pipeQ.delete();
    for (int n = 0; n < LAT - 1; n++) pipeQ.push_back('0);
  endtask

  task automatic modelEdge();
    int unsigned k, idx;
    bit isIo, clr;
    logic [NIN*32-1:0] arrived;
    logic [31:0] nv;
    isIo = malu[IO_SEL_BIT];
    k    = (malu >> 2) % 32;
    idx  = (malu >> 2) % WORDS;
    clr  = mrmem && isIo && (k == 31);
    if (mwmem && !isIo) begin
      ramM[idx] = mb;
      ramV[idx] = 1'b1;
    end
    wrM = '0;
    if (mwmem && isIo && k < NOUT) begin
      outM[k] = mb;
      wrM[k]  = 1'b1;
    end
    pipeQ.push_back(in_ports);
    arrived = pipeQ.pop_front();
    for (int j = 0; j < NIN; j++) begin
      nv = arrived[32*j +: 32];
      if (nv != sM[j]) newM[j] = 1'b1;
      else if (clr)    newM[j] = 1'b0;
      sM[j] = nv;
    end
  endtask

  function automatic logic [31:0] expMmo();
    int unsigned k;
    k = (malu >> 2) % 32;
    if (!malu[IO_SEL_BIT]) return ramM[(malu >> 2) % WORDS];
    if (k < NOUT) return outM[k];
    if (k >= 16 && k < 16 + NIN) return sM[k - 16];
    if (k == 31) return 32'(newM);
    return 32'h0;
  endfunction

  task automatic checkOutput(input string tag);
    if (malu[IO_SEL_BIT] || ramV[(malu >> 2) % WORDS]) check32({tag, ".mmo"}, mmo, expMmo());
    for (int i = 0; i < NOUT; i++) check32($sformatf("%s.out%0d", tag, i), out_ports[32*i +: 32], outM[i]);
    check32({tag, ".out_wr"}, 32'(out_wr), 32'(wrM));
    check32({tag, ".in_new"}, 32'(in_new), 32'(newM));
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] data, input logic [NIN*32-1:0] ins);
    mwmem    = we;
    mrmem    = re;
    malu     = addr;
    mb       = data;
    in_ports = ins;
  endtask

  task automatic finishCycle(input string tag);
    checkOutput(tag);
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic runCycle(input string tag);
    @(negedge clock);
    finishCycle(tag);
  endtask

  logic [NIN*32-1:0] ins;
  int unsigned sel, kk;
  logic [31:0] addr;

  initial begin
    for (int i = 0; i < WORDS; i++) ramV[i] = 1'b0;
    ins = '0;
    applyStimulus(0, 0, 32'h80, 0, ins);
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    runCycle("reset");

    applyStimulus(1, 0, 32'h14, 32'h12345678, ins);
    runCycle("ramWr");
    applyStimulus(0, 0, 32'h14, 0, ins);
    @(negedge clock);
    check32("ramLoad", mmo, 32'h12345678);
    finishCycle("ramLoad");
    applyStimulus(0, 0, 32'h94, 0, ins);
    @(negedge clock);
    check32("unmapped", mmo, 32'h0);
    finishCycle("unmapped");

    applyStimulus(1, 0, 32'h84, 32'hA5, ins);
    runCycle("outWr");
    applyStimulus(0, 0, 32'h84, 0, ins);
    @(negedge clock);
    check32("out1", out_ports[63:32], 32'hA5);
    check32("outWrPulse", 32'(out_wr), 32'h2);
    finishCycle("outRd");
    @(negedge clock);
    check32("outWrDrop", 32'(out_wr), 32'h0);
    check32("outRdBack", mmo, 32'hA5);
    finishCycle("outRd2");

    ins[31:0] = 32'h7;
    applyStimulus(0, 0, 32'hC0, 0, ins);
    repeat (LAT) runCycle("inLat");
    @(negedge clock);
    check32("inSample", mmo, 32'h7);
    check32("inNew0", 32'(in_new[0]), 32'h1);
    finishCycle("inSample");
    applyStimulus(0, 1, 32'hFC, 0, ins);
    @(negedge clock);
    check32("statusPre", mmo, 32'h1);
    finishCycle("statusRd");
    applyStimulus(0, 0, 32'hFC, 0, ins);
    @(negedge clock);
    check32("statusPost", mmo, 32'h0);
    finishCycle("statusPost");

    ins[63:32] = 32'h33;
    applyStimulus(0, 0, 32'h00, 0, ins);
    repeat (LAT - 1) runCycle("setWinsLead");
    applyStimulus(0, 1, 32'hFC, 0, ins);
    runCycle("setWinsRd");
    applyStimulus(0, 0, 32'h80, 0, ins);
    @(negedge clock);
    check32("setWins", 32'(in_new[1]), 32'h1);
    finishCycle("setWins");

    // Bit 7 selects I/O, so the alias is reached through a higher address bit.
    applyStimulus(1, 0, 32'h04, 32'h55, ins);
    runCycle("aliasWr");
    applyStimulus(0, 0, 32'h104, 0, ins);
    @(negedge clock);
    check32("alias", mmo, 32'h55);
    finishCycle("alias");

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        addr = $urandom & ~(32'h1 << IO_SEL_BIT);
      end else begin
        case ($urandom_range(0, 4))
          0, 1:    kk = $urandom_range(0, NOUT - 1);
          2:       kk = 16 + $urandom_range(0, NIN - 1);
          3:       kk = 31;
          default: kk = $urandom_range(0, 31);
        endcase
        addr = ($urandom & ~32'h7C) | (32'h1 << IO_SEL_BIT) | (kk << 2);
      end
      for (int j = 0; j < NIN; j++) begin
        if ($urandom_range(0, 3) == 0) ins[32*j +: 32] = $urandom_range(0, 15);
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, ins);
      runCycle("rand");
    end

    ins = {32'hBEEF, 32'h1234};
    applyStimulus(1, 0, 32'h80, 32'hDEAD, ins);
    runCycle("preRst");
    applyStimulus(0, 0, 32'h80, 0, ins);
    #2 reset = 1'b1;
    #1;
    check32("rstOutPorts", 32'(|out_ports), 32'h0);
    check32("rstOutWr", 32'(out_wr), 32'h0);
    check32("rstInNew", 32'(in_new), 32'h0);
    check32("rstMmo", mmo, 32'h0);
    modelReset();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (LAT + 2) runCycle("postRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
